// File: rtl/t_seq_packer.sv
// t_seq_packer: packs a serial stream of 2-bit nucleotides into 18-bit T words
// for the SRAM controller's T-load port. A word carries 7 bases, a valid bit and
// a last-count. Bases beyond the SRAM word capacity are drained and flagged.
module t_seq_packer #(
  parameter int T_PER_WORD = 7,
  parameter int MAX_WORDS  = 1024,
  parameter int WCNT_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_sram_busy,
  input  logic        i_base_valid,
  input  logic [1:0]  i_base,
  input  logic        i_base_last,
  output logic        o_base_ready,
  output logic        o_start_read_t,
  output logic [17:0] o_t,
  output logic        o_done,
  output logic        o_overflow,
  output logic        o_busy
);

  localparam int DATA_W = 2 * T_PER_WORD;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] buf_ins;
  logic [2:0]        cnt;
  logic [2:0]        cnt_inc;
  logic [WCNT_W-1:0] wcnt;
  logic              accept;
  logic              word_full;
  logic              last_wcnt;

  assign o_base_ready = (state == S_COLLECT) || (state == S_DRAIN);
  assign o_busy       = (state != S_IDLE);
  assign accept       = i_base_valid && o_base_ready;
  assign cnt_inc      = cnt + 3'd1;
  assign word_full    = (cnt_inc == 3'(T_PER_WORD));
  assign last_wcnt    = (wcnt == WCNT_W'(MAX_WORDS - 1));

  // Buffer contents with the incoming base dropped into slot cnt
  always_comb begin
    buf_ins = buf_q;
    for (int k = 0; k < T_PER_WORD; k++) begin
      if (cnt == 3'(k)) buf_ins[2*k +: 2] = i_base;
    end
  end

  // Sequencing, packing and registered output strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      buf_q          <= '0;
      cnt            <= '0;
      wcnt           <= '0;
      o_start_read_t <= 1'b0;
      o_t            <= '0;
      o_done         <= 1'b0;
      o_overflow     <= 1'b0;
    end else begin
      o_start_read_t <= 1'b0;
      o_t            <= '0;
      o_done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start && !i_sram_busy) begin
            state      <= S_START;
            o_overflow <= 1'b0;
            wcnt       <= '0;
            buf_q      <= '0;
            cnt        <= '0;
          end
        end
        S_START: begin
          o_start_read_t <= 1'b1;
          state          <= S_COLLECT;
        end
        S_COLLECT: begin
          if (accept) begin
            if (word_full || i_base_last) begin
              o_t   <= {1'b1, (i_base_last ? cnt_inc : 3'd0), buf_ins};
              buf_q <= '0;
              cnt   <= '0;
              wcnt  <= wcnt + 1'b1;
              if (i_base_last) begin
                state <= S_DONE;
              end else if (last_wcnt) begin
                state      <= S_DRAIN;
                o_overflow <= 1'b1;
              end
            end else begin
              buf_q <= buf_ins;
              cnt   <= cnt_inc;
            end
          end
        end
        S_DRAIN: begin
          if (accept && i_base_last) state <= S_DONE;
        end
        S_DONE: begin
          o_done <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t_seq_packer.sv
// tb_t_seq_packer: randomized and directed sequences checked against a
// behavioural word model. Capacity is shrunk to 4 words so overflow is reachable.
module tb_t_seq_packer;

  localparam int MAXW = 4;
  localparam int TPW  = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_sram_busy;
  logic        i_base_valid;
  logic [1:0]  i_base;
  logic        i_base_last;
  logic        o_base_ready;
  logic        o_start_read_t;
  logic [17:0] o_t;
  logic        o_done;
  logic        o_overflow;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  logic [17:0] obs_word[$];
  int          obs_cyc[$];
  int          start_pulses = 0;
  int          done_pulses  = 0;
  int          done_cyc     = 0;
  int          stray        = 0;

  logic [1:0]  seq_q[$];
  int          acc_cyc[$];

  t_seq_packer #(.T_PER_WORD(TPW), .MAX_WORDS(MAXW), .WCNT_W(2)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_sram_busy(i_sram_busy),
    .i_base_valid(i_base_valid), .i_base(i_base), .i_base_last(i_base_last),
    .o_base_ready(o_base_ready), .o_start_read_t(o_start_read_t), .o_t(o_t),
    .o_done(o_done), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Record strobes, pulses and stray o_t activity once per cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_t[17]) begin
      obs_word.push_back(o_t);
      obs_cyc.push_back(cyc);
    end else if (o_t != 18'd0) begin
      stray = stray + 1;
    end
    if (o_start_read_t) start_pulses = start_pulses + 1;
    if (o_done) begin
      done_pulses = done_pulses + 1;
      done_cyc    = cyc;
    end
  end

  // Global watchdog so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clearStats();
    obs_word.delete();
    obs_cyc.delete();
    acc_cyc.delete();
    start_pulses = 0;
    done_pulses  = 0;
    stray        = 0;
  endtask

  task automatic fillRandom(input int len);
    seq_q.delete();
    for (int i = 0; i < len; i++) seq_q.push_back(2'($urandom_range(3)));
  endtask

  task automatic fillConst(input int len, input logic [1:0] code);
    seq_q.delete();
    for (int i = 0; i < len; i++) seq_q.push_back(code);
  endtask

  // Request a load, optionally while the controller reports busy
  task automatic startLoad(input int busy_cycles);
    @(posedge clk); #1;
    i_start     = 1'b1;
    i_sram_busy = (busy_cycles > 0);
    if (busy_cycles > 0) begin
      repeat (busy_cycles) @(posedge clk);
      #1;
      checkOutput("busy_no_start", start_pulses, 0);
      checkOutput("busy_idle", o_busy, 0);
      i_sram_busy = 1'b0;
    end
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    checkOutput("start_early", o_start_read_t, 0);
    checkOutput("start_ready", o_base_ready, 0);
    @(negedge clk);
    checkOutput("start_pulse", o_start_read_t, 1);
    checkOutput("start_o_t", o_t, 0);
    checkOutput("start_busy", o_busy, 1);
    checkOutput("start_ovf_clr", o_overflow, 0);
  endtask

  // Stream the first count bases of seq_q with random idle gaps
  task automatic applyStimulus(input int count, input int gap_pct);
    int  idx    = 0;
    int  budget = 0;
    logic rdy;
    while (idx < count && budget < 2000) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        i_base_valid = 1'b0;
        i_base_last  = 1'b0;
      end else begin
        i_base_valid = 1'b1;
        i_base       = seq_q[idx];
        i_base_last  = (idx == seq_q.size() - 1);
      end
      rdy = o_base_ready;
      @(posedge clk);
      if (i_base_valid && rdy) begin
        acc_cyc.push_back(cyc);
        idx = idx + 1;
      end
      @(negedge clk);
      budget = budget + 1;
    end
    i_base_valid = 1'b0;
    i_base_last  = 1'b0;
    checkOutput("accept_count", idx, count);
  endtask

  // Compare everything observed against the word model of seq_q
  task automatic checkSequence();
    int          budget = 0;
    int          len;
    int          nw;
    int          emit;
    bit          ovf;
    int          first;
    int          n;
    logic [13:0] data;
    logic [2:0]  lc;
    while (done_pulses == 0 && budget < 20) begin
      @(negedge clk);
      budget = budget + 1;
    end
    repeat (3) @(negedge clk);
    len  = seq_q.size();
    nw   = (len + TPW - 1) / TPW;
    ovf  = (nw > MAXW);
    emit = ovf ? MAXW : nw;
    checkOutput("word_count", obs_word.size(), emit);
    for (int j = 0; j < emit && j < obs_word.size(); j++) begin
      first = TPW * j;
      n     = (len - first < TPW) ? (len - first) : TPW;
      data  = '0;
      for (int k = 0; k < n; k++) data[2*k +: 2] = seq_q[first + k];
      lc = (!ovf && j == emit - 1) ? 3'(n) : 3'd0;
      checkOutput("word", obs_word[j], {1'b1, lc, data});
      if (acc_cyc.size() == len) checkOutput("word_latency", obs_cyc[j], acc_cyc[first + n - 1] + 1);
    end
    if (acc_cyc.size() == len) checkOutput("done_latency", done_cyc, acc_cyc[len - 1] + 2);
    checkOutput("done_pulses", done_pulses, 1);
    checkOutput("overflow", o_overflow, ovf);
    checkOutput("stray_o_t", stray, 0);
    checkOutput("start_pulses", start_pulses, 1);
    checkOutput("end_idle", o_busy, 0);
  endtask

  task automatic runSequence(input int busy_cycles, input int gap_pct);
    clearStats();
    startLoad(busy_cycles);
    applyStimulus(seq_q.size(), gap_pct);
    checkSequence();
  endtask

  initial begin
    rst          = 1'b1;
    i_start      = 1'b0;
    i_sram_busy  = 1'b0;
    i_base_valid = 1'b0;
    i_base       = 2'd0;
    i_base_last  = 1'b0;
    #3;
    checkOutput("reset_outputs", {o_base_ready, o_start_read_t, o_t, o_done, o_overflow, o_busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_idle", {o_base_ready, o_start_read_t, o_t, o_done, o_overflow, o_busy}, 0);

    seq_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    runSequence(0, 0);
    if (obs_word.size() > 0) checkOutput("directed_7", obs_word[0], 18'b1_111_10_01_00_11_10_01_00);

    fillConst(10, 2'd3);
    runSequence(0, 0);
    if (obs_word.size() == 2) begin
      checkOutput("ten_w1", obs_word[0], {1'b1, 3'b000, 14'h3FFF});
      checkOutput("ten_w2", obs_word[1], {1'b1, 3'b011, 8'h00, 6'h3F});
    end

    fillRandom(5);
    runSequence(5, 10);

    fillRandom(40);
    runSequence(0, 20);

    fillRandom(28);
    runSequence(0, 0);

    fillRandom(29);
    runSequence(0, 15);

    fillRandom(9);
    clearStats();
    startLoad(0);
    applyStimulus(3, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("midseq_reset", {o_base_ready, o_start_read_t, o_t, o_done, o_overflow, o_busy}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    fillRandom(2);
    runSequence(0, 0);

    for (int r = 0; r < 8; r++) begin
      fillRandom(int'($urandom_range(1, 35)));
      runSequence(int'($urandom_range(0, 2)), int'($urandom_range(0, 40)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
